// File: rtl/wb_regfile_scoreboard.sv
// rtl/wb_regfile_scoreboard.sv - register file with writeback bypass and busy-bit scoreboard
module wb_regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_sel,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_a,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_b,
  output logic [DATA_WIDTH-1:0]        rd_data_a,
  output logic [DATA_WIDTH-1:0]        rd_data_b,
  input  logic                         src_a_used,
  input  logic                         src_b_used,
  input  logic                         issue_valid,
  input  logic                         issue_writes,
  input  logic [ADDR_WIDTH-1:0]        issue_dst,
  output logic                         stall,
  output logic [(2**ADDR_WIDTH)-1:0]   busy_vec
);

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] mem [NREGS];
  logic [NREGS-1:0]      busy_next;
  logic                  hazard_a;
  logic                  hazard_b;
  logic                  issue_accept;
  logic                  wr_drop;
  logic                  bypass_a;
  logic                  bypass_b;

  // Register 0 swallows writebacks when it is hardwired to zero.
  assign wr_drop  = HAS_ZERO && (wr_sel == '0);
  assign bypass_a = wr_en && (wr_sel == rd_addr_a);
  assign bypass_b = wr_en && (wr_sel == rd_addr_b);

  // Storage update; reset clears every entry and beats any writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && !wr_drop) begin
      mem[wr_sel] <= wr_data;
    end
  end

  // Combinational read ports: zero register, then same-cycle bypass, then storage.
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    rd_data_b = mem[rd_addr_b];
    if (HAS_ZERO && rd_addr_a == '0) begin
      rd_data_a = '0;
    end else if (bypass_a) begin
      rd_data_a = wr_data;
    end
    if (HAS_ZERO && rd_addr_b == '0) begin
      rd_data_b = '0;
    end else if (bypass_b) begin
      rd_data_b = wr_data;
    end
  end

  // A source is hazardous only while its producer is in flight and not arriving this cycle.
  always_comb begin
    hazard_a     = src_a_used && busy_vec[rd_addr_a] && !bypass_a;
    hazard_b     = src_b_used && busy_vec[rd_addr_b] && !bypass_b;
    stall        = hazard_a || hazard_b;
    issue_accept = issue_valid && !stall;
  end

  // Next busy bits: writeback clears first, then an accepted issue sets, so a new producer wins.
  always_comb begin
    busy_next = busy_vec;
    if (wr_en) begin
      busy_next[wr_sel] = 1'b0;
    end
    if (issue_accept && issue_writes && !(HAS_ZERO && issue_dst == '0)) begin
      busy_next[issue_dst] = 1'b1;
    end
  end

  // Scoreboard register; reset drops every pending bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

endmodule
